btn_debounce_multi: RTL

//   N-channel push-button conditioner: 2-FF synchroniser, integrating debouncer,

---
 rtl/btn_debounce_multi_if.sv | 41 ++++
 rtl/btn_debounce_multi.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/btn_debounce_multi_if.sv
// ----------------------------------------------------------------------------
// btn_debounce_multi_if
//   Bundle of the per-channel button signals exchanged between the raw board
//   side (master: drives btn, consumes the conditioned outputs) and the
//   btn_debounce_multi conditioner (slave).
//
//   btn        raw asynchronous button inputs, one bit per channel
//   level_o    debounced level, 1 = pressed
//   press_o    one-cycle pulse on debounced released->pressed
//   release_o  one-cycle pulse on debounced pressed->released
//   long_o     one-cycle pulse when a hold reaches the long-press length
//   held_o     long-press reached and button still pressed
// ----------------------------------------------------------------------------
interface btn_debounce_multi_if #(
    parameter int N_CH = 4
);
    logic [N_CH-1:0] btn;
    logic [N_CH-1:0] level_o;
    logic [N_CH-1:0] press_o;
    logic [N_CH-1:0] release_o;
    logic [N_CH-1:0] long_o;
    logic [N_CH-1:0] held_o;

    modport master (
        output btn,
        input  level_o,
        input  press_o,
        input  release_o,
        input  long_o,
        input  held_o
    );

    modport slave (
        input  btn,
        output level_o,
        output press_o,
        output release_o,
        output long_o,
        output held_o
    );
endinterface : btn_debounce_multi_if

// File: rtl/btn_debounce_multi.sv
// ----------------------------------------------------------------------------
// btn_debounce_multi
//   N-channel push-button conditioner. Each channel passes its raw input
//   through a 2-flop synchroniser, normalises polarity so that 1 = pressed,
//   and integrates it: a level change is only accepted after CNT_MAX
//   consecutive cycles of disagreement with the current debounced level.
//   Accepted changes produce press/release pulses; an optional long-press
//   counter produces a single long_o pulse and a held_o level per press.
//
//   Ports:
//     clk    system clock, all flops rising-edge
//     rst_n  asynchronous active-low reset
//     bus    slave side of btn_debounce_multi_if (btn in, conditioned
//            level_o/press_o/release_o/long_o/held_o out, all registered)
//
//   Parameters:
//     N_CH       number of channels (must match the interface)
//     CNT_MAX    stable cycles required to accept a level change (>=2)
//     LONG_MAX   cycles of debounced hold before long_o; 0 disables it
//     ACTIVE_LOW 1: raw low means pressed; 0: raw high means pressed
// ----------------------------------------------------------------------------
module btn_debounce_multi #(
    parameter int N_CH       = 4,
    parameter int CNT_MAX    = 50000,
    parameter int LONG_MAX   = 0,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    btn_debounce_multi_if.slave   bus
);

    localparam int CW = $clog2(CNT_MAX + 1);
    localparam int LW = (LONG_MAX > 0) ? $clog2(LONG_MAX + 1) : 1;

    // Raw level that corresponds to "released" so the synchroniser resets
    // into a state that does not look like a press.
    localparam logic [N_CH-1:0] IDLE_RAW = (ACTIVE_LOW != 0) ? {N_CH{1'b1}} : {N_CH{1'b0}};
    localparam logic [CW-1:0]   CNT_LAST = CW'(CNT_MAX - 1);

    logic [N_CH-1:0] s1_r;
    logic [N_CH-1:0] s2_r;
    logic [N_CH-1:0] p_s;

    logic [N_CH-1:0] level_s;
    logic [N_CH-1:0] press_s;
    logic [N_CH-1:0] release_s;
    logic [N_CH-1:0] long_s;
    logic [N_CH-1:0] held_s;

    // Two-flop synchroniser for the asynchronous raw inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_r <= IDLE_RAW;
            s2_r <= IDLE_RAW;
        end else begin
            s1_r <= bus.btn;
            s2_r <= s1_r;
        end
    end

    // Polarity normalisation: p_s is 1 whenever the button is pressed.
    always_comb begin
        p_s = {N_CH{1'b0}};
        if (ACTIVE_LOW != 0) begin
            p_s = ~s2_r;
        end else begin
            p_s = s2_r;
        end
    end

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        logic [CW-1:0] cnt_r;
        logic          level_r;
        logic          press_r;
        logic          release_r;
        logic          accept_s;
        logic          level_nxt_s;

        // A change is accepted on the edge where the disagreement has lasted
        // CNT_MAX cycles; level_nxt_s is the debounced level after this edge.
        always_comb begin
            accept_s    = 1'b0;
            level_nxt_s = level_r;
            if ((p_s[c] != level_r) && (cnt_r == CNT_LAST)) begin
                accept_s    = 1'b1;
                level_nxt_s = p_s[c];
            end else begin
                accept_s    = 1'b0;
                level_nxt_s = level_r;
            end
        end

        // Integrating debouncer: any agreement with the current level restarts
        // the count, so bounces never accumulate toward an acceptance.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_r     <= {CW{1'b0}};
                level_r   <= 1'b0;
                press_r   <= 1'b0;
                release_r <= 1'b0;
            end else begin
                press_r   <= accept_s & p_s[c];
                release_r <= accept_s & ~p_s[c];
                level_r   <= level_nxt_s;
                if (p_s[c] == level_r) begin
                    cnt_r <= {CW{1'b0}};
                end else if (accept_s) begin
                    cnt_r <= {CW{1'b0}};
                end else begin
                    cnt_r <= cnt_r + CW'(1);
                end
            end
        end

        assign level_s[c]   = level_r;
        assign press_s[c]   = press_r;
        assign release_s[c] = release_r;

        if (LONG_MAX > 0) begin : g_long
            localparam logic [LW-1:0] LONG_LAST = LW'(LONG_MAX - 1);
            localparam logic [LW-1:0] LONG_TOP  = LW'(LONG_MAX);

            logic [LW-1:0] hcnt_r;
            logic          long_r;
            logic          held_r;
            logic          fire_s;

            // The long-press fires on the edge the hold count reaches its top.
            always_comb begin
                fire_s = 1'b0;
                if (level_r && (hcnt_r == LONG_LAST)) begin
                    fire_s = 1'b1;
                end else begin
                    fire_s = 1'b0;
                end
            end

            // Hold counter saturates at its top so a press yields one long_o;
            // held_o follows the next debounced level so it drops with release_o.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    hcnt_r <= {LW{1'b0}};
                    long_r <= 1'b0;
                    held_r <= 1'b0;
                end else begin
                    long_r <= fire_s;
                    held_r <= level_nxt_s & (held_r | fire_s);
                    if (!level_r) begin
                        hcnt_r <= {LW{1'b0}};
                    end else if (hcnt_r != LONG_TOP) begin
                        hcnt_r <= hcnt_r + LW'(1);
                    end else begin
                        hcnt_r <= hcnt_r;
                    end
                end
            end

            assign long_s[c] = long_r;
            assign held_s[c] = held_r;
        end else begin : g_nolong
            assign long_s[c] = 1'b0;
            assign held_s[c] = 1'b0;
        end
    end

    assign bus.level_o   = level_s;
    assign bus.press_o   = press_s;
    assign bus.release_o = release_s;
    assign bus.long_o    = long_s;
    assign bus.held_o    = held_s;

endmodule : btn_debounce_multi
